analog_axis_emu: RTL and testbench

Multi-port analog-axis synthesiser for the 5200-class cores: per controller port it produces a signed X/Y pot value from one of three sources. The sources are the physical analog stick, a PS/2 mouse routed to one selectable port, or a digital D-pad converted into a ramped analog deflection. It also performs idle recentring of the mouse axis. It sits between hps_io and the core's JOYnX/JOYnY/JOYn inputs and generalises the single-port mouse emulator to N ports, parametrised width, configurable limits and extra modes.

---
 rtl/analog_axis_pkg.sv | 41 ++++
 rtl/analog_axis_chan.sv | 117 +++++++++++
 rtl/analog_axis_emu.sv | 97 +++++++++
 tb/tb_analog_axis_emu.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_axis_pkg.sv
// Shared types and arithmetic helpers for the analog-axis synthesiser.
// Helpers work on int so one body serves every axis width.
package analog_axis_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_MOUSE = 2'd1,
    MODE_DPAD  = 2'd2
  } mode_e;

  // a + b clipped to the signed range of a w-bit value.
  function automatic int sat_add(input int a, input int b, input int w);
    int hi;
    int lo;
    int s;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s  = a + b;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

  function automatic int clamp_delta(input int d, input int lim);
    int r;
    r = d;
    if (r > lim) r = lim;
    else if (r < -lim) r = -lim;
    return r;
  endfunction

  // Move cur toward tgt by at most step, never overshooting.
  function automatic int step_toward(input int cur, input int tgt, input int step);
    int r;
    r = cur;
    if (cur < tgt) r = (cur + step > tgt) ? tgt : cur + step;
    else if (cur > tgt) r = (cur - step < tgt) ? tgt : cur - step;
    return r;
  endfunction

endpackage

// File: rtl/analog_axis_chan.sv
// One controller port: PASS/MOUSE/DPAD mode FSM, X/Y axis registers and D-pad ramp.
// Mouse deltas arrive pre-clamped (and Y pre-inverted) from the top level.
module analog_axis_chan import analog_axis_pkg::*; #(
  parameter int AXIS_W    = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic              CLK_VIDEO,
  input  logic              reset,
  input  logic              halt,
  input  logic [AXIS_W-1:0] joya_x,
  input  logic [AXIS_W-1:0] joya_y,
  input  logic [3:0]        dirs,
  input  logic              dpad_en,
  input  logic              ramp_ce,
  input  logic              mouse_evt,
  input  logic              is_mouse_port,
  input  logic              recenter_tick,
  input  logic signed [AXIS_W:0] dx,
  input  logic signed [AXIS_W:0] dy,
  input  logic [1:0]        btn_in,
  input  logic [1:0]        mouse_btn,
  output logic [AXIS_W-1:0] ax,
  output logic [AXIS_W-1:0] ay,
  output logic [1:0]        btn,
  output logic [1:0]        mode,
  output logic              dig_mask
);

  localparam int AMAX = (1 << (AXIS_W - 1)) - 1;

  mode_e             mode_q, mode_d;
  logic [AXIS_W-1:0] ax_q, ax_d, ay_q, ay_d;
  logic [1:0]        btn_q, btn_d;
  int                cur_x, cur_y, nx, ny, tgt_x, tgt_y;

  always_comb begin
    mode_d = mode_q;
    cur_x  = int'($signed(ax_q));
    cur_y  = int'($signed(ay_q));
    nx     = cur_x;
    ny     = cur_y;
    tgt_x  = 0;
    tgt_y  = 0;
    // dirs = {up, down, left, right}; opposing pairs cancel to centre.
    if (dirs[0] && !dirs[1]) tgt_x = AMAX;
    else if (dirs[1] && !dirs[0]) tgt_x = -AMAX;
    if (dirs[2] && !dirs[3]) tgt_y = AMAX;
    else if (dirs[3] && !dirs[2]) tgt_y = -AMAX;

    if (halt) begin
      mode_d = MODE_PASS;
      nx = 0;
      ny = 0;
    end else if (joya_x != '0 || joya_y != '0) begin
      mode_d = MODE_PASS;
      nx = int'($signed(joya_x));
      ny = int'($signed(joya_y));
    end else if (mouse_evt && is_mouse_port) begin
      mode_d = MODE_MOUSE;
      nx = sat_add(cur_x, int'(dx), AXIS_W);
      ny = sat_add(cur_y, int'(dy), AXIS_W);
    end else if (mouse_evt && mode_q == MODE_MOUSE) begin
      // The mouse has been re-routed to another port.
      mode_d = MODE_PASS;
      nx = 0;
      ny = 0;
    end else if (mode_q == MODE_MOUSE) begin
      if (recenter_tick) begin
        nx = step_toward(cur_x, 0, 1);
        ny = step_toward(cur_y, 0, 1);
      end
    end else if (mode_q == MODE_DPAD && !dpad_en) begin
      mode_d = MODE_PASS;
      nx = 0;
      ny = 0;
    end else if (dpad_en && (dirs != 4'b0000 || mode_q == MODE_DPAD)) begin
      mode_d = MODE_DPAD;
      if (mode_q != MODE_DPAD) begin
        nx = 0;
        ny = 0;
      end
      if (ramp_ce) begin
        nx = step_toward(nx, tgt_x, RAMP_STEP);
        ny = step_toward(ny, tgt_y, RAMP_STEP);
      end
    end else begin
      mode_d = MODE_PASS;
      nx = 0;
      ny = 0;
    end

    ax_d  = AXIS_W'(nx);
    ay_d  = AXIS_W'(ny);
    btn_d = btn_in | ((mode_d == MODE_MOUSE) ? mouse_btn : 2'b00);
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      mode_q <= MODE_PASS;
      ax_q   <= '0;
      ay_q   <= '0;
      btn_q  <= '0;
    end else begin
      mode_q <= mode_d;
      ax_q   <= ax_d;
      ay_q   <= ay_d;
      btn_q  <= btn_d;
    end
  end

  assign ax       = ax_q;
  assign ay       = ay_q;
  assign btn      = btn_q;
  assign mode     = mode_q;
  assign dig_mask = (mode_q != MODE_PASS);

endmodule

// File: rtl/analog_axis_emu.sv
// Multi-port analog-axis synthesiser: mouse strobe detection, delta shaping and
// the shared idle counter live here; per-port behaviour is in analog_axis_chan.
module analog_axis_emu import analog_axis_pkg::*; #(
  parameter int NUM_PORTS   = 4,
  parameter int AXIS_W      = 8,
  parameter int DELTA_LIMIT = 10,
  parameter int RAMP_STEP   = 4,
  parameter int IDLE_TICKS  = 64,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        CLK_VIDEO,
  input  logic                        reset,
  input  logic [24:0]                 mouse_pkt,
  input  logic [PORT_W-1:0]           mouse_port,
  input  logic                        invert_y,
  input  logic                        recenter_en,
  input  logic                        dpad_en,
  input  logic                        ramp_ce,
  input  logic                        halt,
  input  logic [NUM_PORTS*4-1:0]      dig_joy,
  input  logic [NUM_PORTS*2-1:0]      btn_in,
  input  logic [NUM_PORTS*2*AXIS_W-1:0] joya_in,
  output logic [NUM_PORTS*AXIS_W-1:0] ax_out,
  output logic [NUM_PORTS*AXIS_W-1:0] ay_out,
  output logic [NUM_PORTS*2-1:0]      btn_out,
  output logic [NUM_PORTS-1:0]        dig_mask,
  output logic [NUM_PORTS*2-1:0]      mode_out
);

  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TICKS);

  logic                   strobe_q, strobe_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   mouse_evt, recenter_tick;
  logic signed [8:0]      raw_x, raw_y;
  logic signed [AXIS_W:0] dx, dy;
  int                     dx_i, dy_i;
  logic                   unused_pkt_bits;

  assign unused_pkt_bits = ^{mouse_pkt[3:2], mouse_pkt[7:6], mouse_pkt[8], mouse_pkt[16]};

  always_comb begin
    strobe_d  = mouse_pkt[24];
    mouse_evt = mouse_pkt[24] ^ strobe_q;
    // Packet bytes are halved (LSB dropped) before clamping.
    raw_x = {mouse_pkt[4], mouse_pkt[4], mouse_pkt[15:9]};
    raw_y = {mouse_pkt[5], mouse_pkt[5], mouse_pkt[23:17]};
    dx_i  = clamp_delta(int'(raw_x), DELTA_LIMIT);
    dy_i  = clamp_delta(int'(raw_y), DELTA_LIMIT);
    if (invert_y) dy_i = -dy_i;
    dx = (AXIS_W + 1)'(dx_i);
    dy = (AXIS_W + 1)'(dy_i);

    idle_d = idle_q;
    if (mouse_evt) idle_d = '0;
    else if (ramp_ce && idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
    // A packet on the same tick wins: no decay that cycle.
    recenter_tick = ramp_ce && !mouse_evt && recenter_en && (idle_q == IDLE_MAX);
  end

  // The strobe reference reloads even during reset so release sees no edge.
  always_ff @(posedge CLK_VIDEO) begin
    strobe_q <= strobe_d;
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    analog_axis_chan #(
      .AXIS_W    (AXIS_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_chan (
      .CLK_VIDEO     (CLK_VIDEO),
      .reset         (reset),
      .halt          (halt),
      .joya_x        (joya_in[p*2*AXIS_W +: AXIS_W]),
      .joya_y        (joya_in[p*2*AXIS_W + AXIS_W +: AXIS_W]),
      .dirs          (dig_joy[p*4 +: 4]),
      .dpad_en       (dpad_en),
      .ramp_ce       (ramp_ce),
      .mouse_evt     (mouse_evt),
      .is_mouse_port (mouse_port == PORT_W'(p)),
      .recenter_tick (recenter_tick),
      .dx            (dx),
      .dy            (dy),
      .btn_in        (btn_in[p*2 +: 2]),
      .mouse_btn     (mouse_pkt[1:0]),
      .ax            (ax_out[p*AXIS_W +: AXIS_W]),
      .ay            (ay_out[p*AXIS_W +: AXIS_W]),
      .btn           (btn_out[p*2 +: 2]),
      .mode          (mode_out[p*2 +: 2]),
      .dig_mask      (dig_mask[p])
    );
  end

endmodule

// File: tb/tb_analog_axis_emu.sv
// Self-checking bench for analog_axis_emu: directed scenarios with constant
// expectations plus a randomized run checked against a behavioural model.
module tb_analog_axis_emu;
  localparam int NP = 4, W = 8, DL = 10, RS = 4, IT = 64;
  localparam int AMAX = 127, AMIN = -128;
  localparam int PASS = 0, MOUSE = 1, DPAD = 2;

  logic              CLK_VIDEO = 1'b0;
  logic              reset;
  logic [24:0]       mouse_pkt;
  logic [1:0]        mouse_port;
  logic              invert_y, recenter_en, dpad_en, ramp_ce, halt;
  logic [NP*4-1:0]   dig_joy;
  logic [NP*2-1:0]   btn_in;
  logic [NP*2*W-1:0] joya_in;
  logic [NP*W-1:0]   ax_out, ay_out;
  logic [NP*2-1:0]   btn_out, mode_out;
  logic [NP-1:0]     dig_mask;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (plain integers per port).
  int   m_mode[NP], m_ax[NP], m_ay[NP];
  int   m_idle;
  logic m_strobe;
  logic [NP*W-1:0] exp_ax, exp_ay;
  logic [NP*2-1:0] exp_btn, exp_mode;
  logic [NP-1:0]   exp_mask;
  logic [W-1:0]    exp_q[$];

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  analog_axis_emu dut (
    .CLK_VIDEO   (CLK_VIDEO),
    .reset       (reset),
    .mouse_pkt   (mouse_pkt),
    .mouse_port  (mouse_port),
    .invert_y    (invert_y),
    .recenter_en (recenter_en),
    .dpad_en     (dpad_en),
    .ramp_ce     (ramp_ce),
    .halt        (halt),
    .dig_joy     (dig_joy),
    .btn_in      (btn_in),
    .joya_in     (joya_in),
    .ax_out      (ax_out),
    .ay_out      (ay_out),
    .btn_out     (btn_out),
    .dig_mask    (dig_mask),
    .mode_out    (mode_out)
  );

  function automatic int clip(input int v);
    return (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
  endfunction

  function automatic int toward(input int c, input int t, input int s);
    if (c < t) return (t - c < s) ? t : c + s;
    if (c > t) return (c - t < s) ? t : c - s;
    return c;
  endfunction

  // Mouse delta from the packet: 9-bit signed value halved with floor, then clamped.
  function automatic int pkt_delta(input logic sgn, input logic [7:0] b);
    int v;
    v = sgn ? int'(b) - 256 : int'(b);
    v = v >>> 1;
    if (v > DL) v = DL;
    if (v < -DL) v = -DL;
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_clock();
    int dx, dy, jx, jy, tx, ty;
    logic [3:0] d;
    bit evt, tick;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_mode[p] = PASS; m_ax[p] = 0; m_ay[p] = 0;
      end
      m_idle = 0;
    end else begin
      evt  = (mouse_pkt[24] != m_strobe);
      dx   = pkt_delta(mouse_pkt[4], mouse_pkt[15:8]);
      dy   = pkt_delta(mouse_pkt[5], mouse_pkt[23:16]);
      if (invert_y) dy = -dy;
      tick = ramp_ce && !evt && recenter_en && (m_idle == IT);
      if (evt) m_idle = 0;
      else if (ramp_ce && m_idle < IT) m_idle++;
      for (int p = 0; p < NP; p++) begin
        jx = int'($signed(joya_in[p*2*W +: W]));
        jy = int'($signed(joya_in[p*2*W+W +: W]));
        d  = dig_joy[p*4 +: 4];
        tx = (d[0] && !d[1]) ? AMAX : (d[1] && !d[0]) ? -AMAX : 0;
        ty = (d[2] && !d[3]) ? AMAX : (d[3] && !d[2]) ? -AMAX : 0;
        if (halt) begin
          m_mode[p] = PASS; m_ax[p] = 0; m_ay[p] = 0;
        end else if (jx != 0 || jy != 0) begin
          m_mode[p] = PASS; m_ax[p] = jx; m_ay[p] = jy;
        end else if (evt && p == int'(mouse_port)) begin
          m_mode[p] = MOUSE; m_ax[p] = clip(m_ax[p] + dx); m_ay[p] = clip(m_ay[p] + dy);
        end else if (evt && m_mode[p] == MOUSE) begin
          m_mode[p] = PASS; m_ax[p] = 0; m_ay[p] = 0;
        end else if (m_mode[p] == MOUSE) begin
          if (tick) begin m_ax[p] = toward(m_ax[p], 0, 1); m_ay[p] = toward(m_ay[p], 0, 1); end
        end else if (m_mode[p] == DPAD && !dpad_en) begin
          m_mode[p] = PASS; m_ax[p] = 0; m_ay[p] = 0;
        end else if (dpad_en && (d != 0 || m_mode[p] == DPAD)) begin
          if (m_mode[p] != DPAD) begin m_ax[p] = 0; m_ay[p] = 0; end
          m_mode[p] = DPAD;
          if (ramp_ce) begin m_ax[p] = toward(m_ax[p], tx, RS); m_ay[p] = toward(m_ay[p], ty, RS); end
        end else begin
          m_mode[p] = PASS; m_ax[p] = 0; m_ay[p] = 0;
        end
      end
    end
    m_strobe = mouse_pkt[24];
    for (int p = 0; p < NP; p++) begin
      exp_ax[p*W +: W]   = W'(m_ax[p]);
      exp_ay[p*W +: W]   = W'(m_ay[p]);
      exp_mode[p*2 +: 2] = 2'(m_mode[p]);
      exp_mask[p]        = (m_mode[p] != PASS);
      exp_btn[p*2 +: 2]  = reset ? 2'b00 :
                           btn_in[p*2 +: 2] | ((m_mode[p] == MOUSE) ? mouse_pkt[1:0] : 2'b00);
    end
  endtask

  task automatic cycle();
    model_clock();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  task automatic ramp_pulse();
    ramp_ce = 1'b1; cycle(); ramp_ce = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic sx, input logic [7:0] y,
                          input logic sy, input logic [1:0] b);
    mouse_pkt = {~mouse_pkt[24], y, x, 2'b00, sy, sx, 2'b00, b};
  endtask

  task automatic do_reset();
    reset = 1'b1; invert_y = 0; recenter_en = 0; dpad_en = 0; ramp_ce = 0; halt = 0;
    dig_joy = '0; btn_in = '0; joya_in = '0; mouse_port = 2'd0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mouse_pkt = 25'h1000000;
    do_reset();
    vectors++; if ({mode_out, dig_mask, btn_out} !== '0) begin miscompares++;
      $display("FAIL reset_ctrl got mode=%h mask=%h btn=%h exp 0", mode_out, dig_mask, btn_out); end
    vectors++; if ({ax_out, ay_out} !== '0) begin miscompares++;
      $display("FAIL reset_axes got ax=%h ay=%h exp 0", ax_out, ay_out); end
    cycle(); cycle(); cycle();
    vectors++; if (mode_out !== '0) begin miscompares++;
      $display("FAIL reset_no_phantom got mode=%h exp 0", mode_out); end
  endtask

  task automatic test_mouse_basic();
    send_pkt(8'd10, 1'b0, 8'd0, 1'b0, 2'b01);
    cycle();
    vectors++; if (mode_out !== 8'h01) begin miscompares++;
      $display("FAIL mouse_mode got %h exp 01", mode_out); end
    vectors++; if (ax_out[7:0] !== 8'd5) begin miscompares++;
      $display("FAIL mouse_ax got %0d exp 5", ax_out[7:0]); end
    vectors++; if (dig_mask !== 4'b0001 || btn_out[1:0] !== 2'b01) begin miscompares++;
      $display("FAIL mouse_mask_btn got mask=%b btn=%b exp 0001/01", dig_mask, btn_out[1:0]); end
    cycle();
    vectors++; if (ax_out[7:0] !== 8'd5) begin miscompares++;
      $display("FAIL mouse_single_accum got %0d exp 5", ax_out[7:0]); end
  endtask

  task automatic test_back_to_back();
    int e;
    for (int i = 0; i < 20; i++) begin
      send_pkt(8'd100, 1'b0, 8'd0, 1'b0, 2'b00);
      cycle();
      e = 5 + 10 * (i + 1);
      if (e > AMAX) e = AMAX;
      vectors++; if (ax_out[7:0] !== 8'(e)) begin miscompares++;
        $display("FAIL b2b_sat[%0d] got %0d exp %0d", i, ax_out[7:0], e); end
    end
    invert_y = 1'b1;
    send_pkt(8'd0, 1'b0, 8'd6, 1'b0, 2'b00);
    cycle();
    invert_y = 1'b0;
    vectors++; if (ay_out[7:0] !== 8'hFD || ax_out[7:0] !== 8'd127) begin miscompares++;
      $display("FAIL invert_y got ay=%h ax=%0d exp FD/127", ay_out[7:0], ax_out[7:0]); end
    send_pkt(8'd0, 1'b1, 8'd0, 1'b0, 2'b00);
    cycle();
    vectors++; if (ax_out[7:0] !== 8'd117) begin miscompares++;
      $display("FAIL neg_clamp got %0d exp 117", ax_out[7:0]); end
  endtask

  task automatic test_override();
    joya_in[7:0] = 8'h20;
    cycle();
    vectors++; if (mode_out[1:0] !== 2'd0 || ax_out[7:0] !== 8'h20 || dig_mask[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL joya_override got mode=%0d ax=%h mask=%b exp 0/20/0", mode_out[1:0], ax_out[7:0], dig_mask[0]); end
    joya_in = '0;
    dpad_en = 1'b1; dig_joy[15:12] = 4'b0001;
    cycle(); ramp_pulse(); ramp_pulse();
    send_pkt(8'd10, 1'b0, 8'd0, 1'b0, 2'b00);
    cycle();
    vectors++; if (mode_out !== 8'h81 || ax_out[31:24] !== 8'd8) begin miscompares++;
      $display("FAIL pre_halt got mode=%h ax3=%0d exp 81/8", mode_out, ax_out[31:24]); end
    halt = 1'b1;
    cycle();
    vectors++; if (mode_out !== '0 || ax_out !== '0 || ay_out !== '0) begin miscompares++;
      $display("FAIL halt got mode=%h ax=%h ay=%h exp 0", mode_out, ax_out, ay_out); end
    halt = 1'b0; dpad_en = 1'b0; dig_joy = '0;
  endtask

  task automatic test_port_move();
    do_reset();
    send_pkt(8'd8, 1'b0, 8'd0, 1'b0, 2'b00);
    cycle();
    mouse_port = 2'd2;
    cycle();
    vectors++; if (mode_out !== 8'h01 || ax_out[7:0] !== 8'd4) begin miscompares++;
      $display("FAIL move_hold got mode=%h ax0=%0d exp 01/4", mode_out, ax_out[7:0]); end
    send_pkt(8'd6, 1'b0, 8'd0, 1'b0, 2'b00);
    cycle();
    vectors++; if (mode_out !== 8'h10 || ax_out[23:16] !== 8'd3 || ax_out[7:0] !== 8'd0) begin
      miscompares++;
      $display("FAIL move_event got mode=%h ax2=%0d ax0=%0d exp 10/3/0", mode_out, ax_out[23:16], ax_out[7:0]); end
    mouse_port = 2'd0;
  endtask

  task automatic test_dpad_ramp();
    logic [W-1:0] e;
    do_reset();
    dpad_en = 1'b1; dig_joy[7:4] = 4'b0001;
    cycle();
    vectors++; if (mode_out[3:2] !== 2'd2 || dig_mask[1] !== 1'b1 || ax_out[15:8] !== 8'd0) begin
      miscompares++;
      $display("FAIL dpad_enter got mode=%0d mask=%b ax=%0d exp 2/1/0", mode_out[3:2], dig_mask[1], ax_out[15:8]); end
    for (int v = RS; v < AMAX; v += RS) exp_q.push_back(W'(v));
    exp_q.push_back(W'(AMAX));
    for (int v = AMAX - RS; v > 0; v -= RS) exp_q.push_back(W'(v));
    exp_q.push_back(W'(0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      if (ax_out[15:8] == 8'd127) dig_joy[7:4] = 4'b0000;
      ramp_pulse(); cycle(); cycle(); cycle();
      e = exp_q.pop_front();
      vectors++; if (ax_out[15:8] !== e) begin miscompares++;
        $display("FAIL dpad_step[%0d] got %0d exp %0d", n, ax_out[15:8], e); end
    end
    dig_joy[7:4] = 4'b0010;
    ramp_pulse(); ramp_pulse();
    vectors++; if (ax_out[15:8] !== 8'hF8 || ay_out[15:8] !== 8'd0 || mode_out[3:2] !== 2'd2) begin
      miscompares++;
      $display("FAIL dpad_left got ax=%h ay=%h mode=%0d exp F8/00/2", ax_out[15:8], ay_out[15:8], mode_out[3:2]); end
    dpad_en = 1'b0;
    cycle();
    vectors++; if (mode_out[3:2] !== 2'd0 || ax_out[15:8] !== 8'd0) begin miscompares++;
      $display("FAIL dpad_off got mode=%0d ax=%0d exp 0/0", mode_out[3:2], ax_out[15:8]); end
    dig_joy = '0;
  endtask

  task automatic test_recenter();
    do_reset();
    send_pkt(8'd20, 1'b0, 8'd0, 1'b0, 2'b00);
    cycle();
    recenter_en = 1'b1;
    for (int i = 0; i < IT; i++) begin ramp_pulse(); cycle(); end
    vectors++; if (ax_out[7:0] !== 8'd10) begin miscompares++;
      $display("FAIL idle_wait got %0d exp 10", ax_out[7:0]); end
    for (int k = 9; k >= -1; k--) begin
      ramp_pulse(); cycle();
      vectors++; if (ax_out[7:0] !== 8'((k < 0) ? 0 : k) || mode_out[1:0] !== 2'd1) begin
        miscompares++;
        $display("FAIL decay[%0d] got ax=%0d mode=%0d exp %0d/1", k, ax_out[7:0], mode_out[1:0], (k < 0) ? 0 : k); end
    end
    ramp_ce = 1'b1;
    send_pkt(8'd6, 1'b0, 8'd0, 1'b0, 2'b00);
    cycle();
    ramp_ce = 1'b0;
    vectors++; if (ax_out[7:0] !== 8'd3) begin miscompares++;
      $display("FAIL evt_vs_tick got %0d exp 3", ax_out[7:0]); end
    cycle(); ramp_pulse(); cycle();
    vectors++; if (ax_out[7:0] !== 8'd3) begin miscompares++;
      $display("FAIL idle_cleared got %0d exp 3", ax_out[7:0]); end
    recenter_en = 1'b0;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    send_pkt(8'd10, 1'b0, 8'd0, 1'b0, 2'b00);
    dpad_en = 1'b1; dig_joy[11:8] = 4'b0100;
    cycle(); ramp_pulse(); ramp_pulse(); ramp_pulse();
    vectors++; if (ay_out[23:16] !== 8'd12 || ax_out[7:0] !== 8'd5) begin miscompares++;
      $display("FAIL pre_reset got ay2=%0d ax0=%0d exp 12/5", ay_out[23:16], ax_out[7:0]); end
    reset = 1'b1;
    send_pkt(8'd10, 1'b0, 8'd0, 1'b0, 2'b11);
    cycle();
    send_pkt(8'd10, 1'b0, 8'd0, 1'b0, 2'b11);
    cycle();
    vectors++; if ({mode_out, dig_mask, btn_out, ax_out, ay_out} !== '0) begin miscompares++;
      $display("FAIL mid_reset got mode=%h ax=%h ay=%h exp 0", mode_out, ax_out, ay_out); end
    dig_joy = '0; dpad_en = 1'b0; reset = 1'b0;
    cycle(); cycle(); cycle();
    vectors++; if (mode_out !== '0 || ax_out !== '0 || btn_out !== '0) begin miscompares++;
      $display("FAIL post_reset got mode=%h ax=%h btn=%h exp 0", mode_out, ax_out, btn_out); end
  endtask

  task automatic test_random(input int n, input int evt_div);
    int p;
    do_reset();
    dpad_en = 1'b1;
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, evt_div - 1) == 0)
        send_pkt(8'($urandom_range(0, 40)), 1'($urandom), 8'($urandom_range(0, 40)), 1'($urandom), 2'($urandom));
      else mouse_pkt[1:0] = 2'($urandom);
      if ($urandom_range(0, 39) == 0) mouse_port = 2'($urandom);
      if ($urandom_range(0, 49) == 0) invert_y = ~invert_y;
      if ($urandom_range(0, 99) == 0) recenter_en = ~recenter_en;
      if ($urandom_range(0, 59) == 0) dpad_en = ~dpad_en;
      if ($urandom_range(0, 9) == 0) dig_joy = 16'($urandom);
      ramp_ce = ($urandom_range(0, 2) == 0);
      halt    = ($urandom_range(0, 99) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      btn_in  = 8'($urandom);
      p = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 19) == 0) joya_in[p*2*W +: 2*W] = 16'($urandom);
      else if ($urandom_range(0, 7) == 0) joya_in[p*2*W +: 2*W] = '0;
      cycle();
      vectors++;
      if ({mode_out, dig_mask, btn_out, ax_out, ay_out} !== {exp_mode, exp_mask, exp_btn, exp_ax, exp_ay}) begin
        miscompares++;
        $display("FAIL random[%0d] got mode=%h mask=%h btn=%h ax=%h ay=%h exp mode=%h mask=%h btn=%h ax=%h ay=%h",
                 c, mode_out, dig_mask, btn_out, ax_out, ay_out, exp_mode, exp_mask, exp_btn, exp_ax, exp_ay);
      end
    end
    reset = 1'b0; halt = 1'b0; ramp_ce = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mouse_pkt = '0; mouse_port = '0; invert_y = 0; recenter_en = 0;
    dpad_en = 0; ramp_ce = 0; halt = 0; dig_joy = '0; btn_in = '0; joya_in = '0;
    test_reset();
    test_mouse_basic();
    test_back_to_back();
    test_override();
    test_port_move();
    test_dpad_ramp();
    test_recenter();
    test_reset_mid_ramp();
    test_random(3000, 3);
    test_random(3000, 150);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
